ram_access_ctrl: RTL and testbench

- Request-side controller placed directly upstream of the single-port 1024x16 RAM (clk, WE, address, dataIn, dataOut).
- Converts a valid/ready request stream (single read or write) into correctly timed RAM strobes and returns read data as a one-cycle response pulse.
- Also provides a hardware clear/fill sweep that writes a constant value to every RAM word.

---
 rtl/ram_ctrl_pkg.sv | 20 ++
 rtl/ram_access_ctrl.sv | 139 +++++++++++++
 tb/tb_ram_access_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and sizing for the single-port RAM request controller.
// Defaults match the 1024x16 RAM; read latency bounds size the wait counter.
package ram_ctrl_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 16;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_READ_CAP,
        ST_CLEAR
    } state_e;

endpackage

// File: rtl/ram_access_ctrl.sv
// Valid/ready front end for a single-port RAM: timed read/write strobes,
// registered read response pulse, and a full-depth constant fill sweep.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = RAM_ADDR_W,
    parameter int DATA_WIDTH   = RAM_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_value,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [LAT_CNT_W-1:0]  LAT_INIT  = LAT_CNT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

    state_e                  state_q, state_d;
    logic [LAT_CNT_W-1:0]    lat_q, lat_d;
    logic                    ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_din_q, ram_din_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    clr_busy_q, clr_busy_d;
    logic                    clr_done_q, clr_done_d;

    assign req_ready = (state_q == ST_IDLE) && !clr_start && !rst;

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        clr_busy_d  = 1'b0;
        clr_done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    // ram_din doubles as the latched fill value
                    state_d    = ST_CLEAR;
                    ram_we_d   = 1'b1;
                    ram_addr_d = '0;
                    ram_din_d  = clr_value;
                    clr_busy_d = 1'b1;
                end else if (req_valid) begin
                    ram_addr_d = req_addr;
                    if (req_we) begin
                        state_d   = ST_WRITE;
                        ram_we_d  = 1'b1;
                        ram_din_d = req_wdata;
                    end else begin
                        state_d = ST_READ_WAIT;
                        lat_d   = LAT_INIT;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_READ_WAIT: begin
                if (lat_q == '0) begin
                    state_d = ST_READ_CAP;
                end else begin
                    lat_d = lat_q - LAT_CNT_W'(1);
                end
            end
            ST_READ_CAP: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = ram_dout;
            end
            ST_CLEAR: begin
                // equality stop keeps the address parked on the last word
                if (ram_addr_q == ADDR_LAST) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    ram_we_d   = 1'b1;
                    clr_busy_d = 1'b1;
                    ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            clr_busy_q  <= clr_busy_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign clr_busy  = clr_busy_q;
    assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed + random bench for ram_access_ctrl with a behavioural 1-cycle RAM
// and an array model of the memory contents.
module tb_ram_access_ctrl;
    import ram_ctrl_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int RL    = 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_value = '0;
    logic          clr_busy;
    logic          clr_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] model   [DEPTH];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    ram_access_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(RL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .clr_start(clr_start),
        .clr_value(clr_value),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ready_timeout", 64'(n < 50), 64'd1);
    endtask

    task automatic scramble();
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
        req_we    = 1'($urandom);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        chk("wr_strobe", {ram_we, ram_addr, ram_din}, {1'b1, a, d});
        chk("wr_ready_low", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        scramble();
        @(negedge clk);
        chk("wr_end", {req_ready, ram_we}, 2'b10);
        model[a] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        logic [DW-1:0] exp;
        exp = model[a];
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        scramble();
        for (int k = 1; k <= RL + 1; k++) begin
            chk("rd_wait", {ram_we, ram_addr, rsp_valid, req_ready},
                {1'b0, a, 1'b0, 1'b0});
            @(negedge clk);
        end
        chk("rd_rsp", {rsp_valid, rsp_data, req_ready, ram_we},
            {1'b1, exp, 1'b1, 1'b0});
        @(negedge clk);
        chk("rd_pulse_end", {rsp_valid, rsp_data}, {1'b0, exp});
    endtask

    task automatic run_sweep(input logic [DW-1:0] v, input bit pend,
                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        wait_ready();
        clr_start = 1'b1;
        clr_value = v;
        if (pend) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = wa;
            req_wdata = wd;
        end
        #1;
        chk("clr_priority", 64'(req_ready), 64'd0);
        @(negedge clk);
        clr_start = 1'b0;
        clr_value = DW'($urandom);
        for (int i = 0; i < DEPTH; i++) begin
            chk("clr_beat",
                {ram_we, ram_addr, ram_din, clr_busy, clr_done, req_ready},
                {1'b1, AW'(i), v, 1'b1, 1'b0, 1'b0});
            clr_start = (i == 5);
            @(negedge clk);
        end
        clr_start = 1'b0;
        chk("clr_done", {ram_we, ram_addr, clr_busy, clr_done, req_ready},
            {1'b0, AW'(DEPTH - 1), 1'b0, 1'b1, 1'b1});
        for (int i = 0; i < DEPTH; i++) model[i] = v;
        @(negedge clk);
        chk("clr_done_pulse", {clr_done, clr_busy}, 2'b00);
        if (pend) begin
            chk("stalled_wr", {ram_we, ram_addr, ram_din}, {1'b1, wa, wd});
            req_valid = 1'b0;
            scramble();
            @(negedge clk);
            model[wa] = wd;
        end
    endtask

    initial begin
        logic [DW-1:0] fill;
        logic [DW-1:0] prior;
        logic [AW-1:0] a;

        @(negedge clk);
        chk("reset_outs",
            {ram_we, ram_addr, ram_din, rsp_valid, rsp_data,
             clr_busy, clr_done, req_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(req_ready), 64'd1);
        @(negedge clk);
        chk("ready_first_cycle", 64'(req_ready), 64'd1);

        do_write(AW'(1), 16'hABCC);
        do_read(AW'(1));

        run_sweep(16'h0000, 1'b0, '0, '0);
        do_read(AW'(1));
        do_read(AW'(DEPTH - 1));

        run_sweep(DW'($urandom), 1'b1, AW'(4), 16'h1234);
        do_read(AW'(4));

        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) :
                AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom));
            else do_read(a);
        end

        prior = DW'($urandom);
        do_write(AW'(12'h200), prior);
        fill = DW'($urandom) | 16'h0001;
        wait_ready();
        clr_start = 1'b1;
        clr_value = fill;
        @(negedge clk);
        clr_start = 1'b0;
        for (int i = 0; i <= 'h100; i++) begin
            chk("abort_beat", {ram_we, ram_addr, ram_din, clr_busy},
                {1'b1, AW'(i), fill, 1'b1});
            if (i < 'h100) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("abort_outs",
            {ram_we, ram_addr, ram_din, rsp_valid, rsp_data,
             clr_busy, clr_done, req_ready}, 64'd0);
        for (int i = 0; i < 256; i++) model[i] = fill;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", {clr_done, clr_busy, req_ready}, 3'b000);
        end
        rst = 1'b0;
        #1;
        chk("abort_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        chk("abort_quiet", {clr_done, clr_busy, ram_we, req_ready}, 4'b0001);
        do_read(AW'(12'h0FF));
        do_read(AW'(12'h200));
        do_read(AW'(12'h000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
